uart_tx_arbiter: RTL and testbench

- Shares one CoreUART transmitter between N_REQ byte producers using round-robin arbitration with message locking.
- Writes the chosen byte into the transmitter holding register with a one-cycle load strobe.
- Tracks the transmitter's txrdy handshake and sequences the next grant.
- Sits between the requester logic and the UART Tx path.

---
 rtl/uart_arb_pkg.sv | 26 ++
 rtl/uart_tx_rr_pick.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter: FSM state encoding,
// default timing parameters and a constant-width helper.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    GAP       = 3'd4
  } state_t;

  localparam int DEF_N_REQ        = 4;
  localparam int DEF_GAP_CYCLES   = 0;
  localparam int DEF_LOCK_TIMEOUT = 255;
  localparam int DEF_LOAD_TIMEOUT = 4;

  // Ceiling log2 for elaboration-time widths; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_rr_pick.sv
// Combinational rotating-priority picker: scans the eligible vector starting at
// 'start', wrapping, and returns the first set index.
module uart_tx_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDW   = (N_REQ > 1) ? clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IDW-1:0]   start,
  output logic [IDW-1:0]   winner,
  output logic             found
);

  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  int                 sum;

  always_comb begin
    // NOTE: every output and temporary gets a default before the loop, so no
    // path through this block leaves a value held and no latch is inferred.
    winner  = '0;
    found   = 1'b0;
    sum     = 0;
    doubled = {eligible, eligible} >> start;
    rotated = doubled[N_REQ-1:0];
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && rotated[i]) begin
        found  = 1'b1;
        sum    = int'(start) + i;
        winner = IDW'((sum >= N_REQ) ? sum - N_REQ : sum);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with message locking that shares one CoreUART transmitter
// between N_REQ byte producers and sequences the txrdy load handshake.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ        = DEF_N_REQ,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LOAD_TIMEOUT = DEF_LOAD_TIMEOUT,
  parameter int IDW          = (N_REQ > 1) ? clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_hold_reg,
  output logic               tx_load,
  input  logic               txrdy,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic               lock_active,
  output logic               load_err
);

  state_t           state;
  logic [15:0]      cnt;
  logic [7:0]       lock_cnt;
  logic             granted_once;

  logic [N_REQ-1:0] lock_mask;
  logic [N_REQ-1:0] eligible;
  logic             locked_valid;
  logic [IDW-1:0]   start;
  logic [IDW-1:0]   winner;
  logic             found;
  logic [7:0]       win_data;
  logic             win_last;

  // Until the first grant the search begins at requester 0; afterwards it
  // begins just past the last winner.
  always_comb begin
    lock_mask    = N_REQ'(1) << grant_id;
    locked_valid = |(req_valid & lock_mask);
    eligible     = lock_active ? (req_valid & lock_mask) : req_valid;
    start        = '0;
    if (granted_once && (grant_id != IDW'(N_REQ - 1)))
      start = grant_id + IDW'(1);
  end

  uart_tx_rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .eligible (eligible),
    .start    (start),
    .winner   (winner),
    .found    (found)
  );

  always_comb begin
    win_data = '0;
    win_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == IDW'(i)) begin
        win_data = req_data[8*i +: 8];
        win_last = req_last[i];
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments, so every register is
  // updated from the values present before the edge regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      lock_cnt     <= '0;
      granted_once <= 1'b0;
      req_ready    <= '0;
      tx_hold_reg  <= '0;
      tx_load      <= 1'b0;
      grant_id     <= '0;
      busy         <= 1'b0;
      lock_active  <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      req_ready <= '0;
      tx_load   <= 1'b0;
      load_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (txrdy && found) begin
            state        <= LOAD;
            busy         <= 1'b1;
            tx_load      <= 1'b1;
            req_ready    <= N_REQ'(1) << winner;
            tx_hold_reg  <= win_data;
            grant_id     <= winner;
            granted_once <= 1'b1;
            lock_active  <= ~win_last;
            lock_cnt     <= '0;
          end else if (lock_active && !locked_valid) begin
            // A silent lock owner eventually forfeits the lock.
            if (lock_cnt == 8'(LOCK_TIMEOUT - 1)) begin
              lock_active <= 1'b0;
              lock_cnt    <= '0;
            end else begin
              lock_cnt <= lock_cnt + 8'd1;
            end
          end
        end
        LOAD: begin
          state <= WAIT_LOW;
          cnt   <= '0;
        end
        WAIT_LOW: begin
          if (!txrdy) begin
            state <= WAIT_HIGH;
          end else if (cnt == 16'(LOAD_TIMEOUT - 1)) begin
            // The UART never took the byte; report it and move on.
            load_err <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_HIGH: begin
          if (txrdy) begin
            if (GAP_CYCLES > 0) begin
              state <= GAP;
              cnt   <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        GAP: begin
          if (cnt == 16'(GAP_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester and UART models drive the DUT,
// a scoreboard queue holds the expected grant sequence.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } req_t;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       lock;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_hold_reg;
  logic           tx_load;
  logic           txrdy;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           lock_active;
  logic           load_err;

  int   compares = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_load_cyc = 0;
  int   last_rise_cyc = 0;
  int   uart_mode = 0;  // 0: normal handshake, 1: stuck with txrdy high

  req_t rq [N][$];
  exp_t exp_q[$];

  uart_tx_arbiter #(
    .N_REQ        (N),
    .GAP_CYCLES   (3),
    .LOCK_TIMEOUT (8),
    .LOAD_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_hold_reg (tx_hold_reg),
    .tx_load     (tx_load),
    .txrdy       (txrdy),
    .grant_id    (grant_id),
    .busy        (busy),
    .lock_active (lock_active),
    .load_err    (load_err)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int r, input logic [7:0] d, input logic last);
    req_t e;
    e.data = d;
    e.last = last;
    rq[r].push_back(e);
  endtask

  task automatic expect_grant(input int id, input logic [7:0] d, input logic lock);
    exp_t e;
    e.id   = id;
    e.data = d;
    e.lock = lock;
    exp_q.push_back(e);
  endtask

  task automatic wait_sb(input int left, input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > left && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'(left));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy !== 1'b0 || txrdy !== 1'b1) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"},   32'(req_ready),   32'd0);
    check({tag, "_tx_hold_reg"}, 32'(tx_hold_reg), 32'd0);
    check({tag, "_tx_load"},     32'(tx_load),     32'd0);
    check({tag, "_grant_id"},    32'(grant_id),    32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_lock_active"}, 32'(lock_active), 32'd0);
    check({tag, "_load_err"},    32'(load_err),    32'd0);
  endtask

  // Requesters: present the head of each queue, advance after an accept pulse.
  initial begin
    logic [N-1:0] rdy;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rdy[i] === 1'b1 && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = rq[i][0].data;
          req_last[i]        = rq[i][0].last;
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // UART: txrdy drops one clock after a load and returns 20 clocks later.
  initial begin
    int   hold;
    logic ld;
    hold  = 0;
    txrdy = 1'b1;
    forever begin
      @(negedge clk);
      ld = tx_load;
      @(posedge clk);
      #1;
      if (uart_mode == 1) begin
        txrdy = 1'b1;
        hold  = 0;
      end else if (ld === 1'b1) begin
        txrdy = 1'b0;
        hold  = 20;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          txrdy         = 1'b1;
          last_rise_cyc = cyc;
        end
      end
    end
  end

  // Scoreboard: every load strobe must match the oldest expected grant.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (tx_load === 1'b1) begin
      last_load_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_load", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("sb_grant_id",    32'(grant_id),    32'(e.id));
        check("sb_tx_hold_reg", 32'(tx_hold_reg), 32'(e.data));
        check("sb_req_ready",   32'(req_ready),   32'(4'(1) << e.id));
        check("sb_lock_active", 32'(lock_active), 32'(e.lock));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int d;
    int idle_cyc;
    int lock_cyc;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check_reset_values("rst");
    @(posedge clk);
    #1 reset = 1'b0;

    // Single requester, one-cycle latency from qualifying sample to strobe
    send(2, 8'h5A, 1'b1);
    expect_grant(2, 8'h5A, 1'b0);
    n = 0;
    while (req_valid[2] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("t1_valid_seen", 32'(req_valid[2]), 32'd1);
    tick();
    check("t1_load_latency", 32'(tx_load), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    wait_sb(0, "t1_done", 50);
    wait_idle("t1_idle", 100);

    // Fairness from a fresh pointer: 0,1,2,3,0
    do_reset();
    send(0, 8'hA0, 1'b1);
    send(0, 8'hA1, 1'b1);
    send(1, 8'hB0, 1'b1);
    send(2, 8'hC0, 1'b1);
    send(3, 8'hD0, 1'b1);
    expect_grant(0, 8'hA0, 1'b0);
    expect_grant(1, 8'hB0, 1'b0);
    expect_grant(2, 8'hC0, 1'b0);
    expect_grant(3, 8'hD0, 1'b0);
    expect_grant(0, 8'hA1, 1'b0);
    wait_sb(0, "t2_done", 400);
    wait_idle("t2_idle", 100);

    // Message lock holds requester 1 for both bytes, then 3, then 0
    send(0, 8'h33, 1'b1);
    send(1, 8'h11, 1'b0);
    send(1, 8'h22, 1'b1);
    send(3, 8'h44, 1'b1);
    expect_grant(1, 8'h11, 1'b1);
    expect_grant(1, 8'h22, 1'b0);
    expect_grant(3, 8'h44, 1'b0);
    expect_grant(0, 8'h33, 1'b0);
    wait_sb(3, "t3_first", 100);
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    check("t3_lock_between", 32'(lock_active), 32'd1);
    wait_sb(0, "t3_done", 400);
    wait_idle("t3_idle", 100);

    // Lock timeout: requester 1 locks and goes quiet while 0 waits
    send(1, 8'h55, 1'b0);
    send(0, 8'h66, 1'b1);
    expect_grant(1, 8'h55, 1'b1);
    expect_grant(0, 8'h66, 1'b0);
    wait_sb(1, "t4_first", 100);
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    idle_cyc = cyc;
    check("t4_locked_in_idle", 32'(lock_active), 32'd1);
    n = 0;
    while (lock_active !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    lock_cyc = cyc;
    d = lock_cyc - idle_cyc;
    check("t4_lock_drop_not_early", 32'(d >= 8), 32'd1);
    check("t4_lock_drop_not_late",  32'(d <= 9), 32'd1);
    wait_sb(0, "t4_done", 50);
    check("t4_grant_next_cycle", 32'(last_load_cyc - lock_cyc), 32'd1);
    wait_idle("t4_idle", 100);

    // UART stuck with txrdy high: load_err four cycles after WAIT_LOW entry
    uart_mode = 1;
    send(2, 8'h77, 1'b1);
    expect_grant(2, 8'h77, 1'b0);
    wait_sb(0, "t5_load", 50);
    while (cyc < last_load_cyc + 6) begin
      tick();
      d = cyc - last_load_cyc;
      if (d >= 4) check($sformatf("t5_load_err_d%0d", d), 32'(load_err), 32'(d == 5));
      if (d == 5) check("t5_back_to_idle", 32'(busy), 32'd0);
    end
    uart_mode = 0;
    tick();
    tick();

    // Reset during WAIT_HIGH, then a run with a three-cycle gap
    send(0, 8'h88, 1'b0);
    expect_grant(0, 8'h88, 1'b1);
    wait_sb(0, "t6_load", 50);
    repeat (5) tick();
    check("t6_busy_before_reset", 32'(busy), 32'd1);
    do_reset();
    tick();
    check_reset_values("t6_rst");
    send(0, 8'h99, 1'b1);
    send(1, 8'hAA, 1'b1);
    expect_grant(0, 8'h99, 1'b0);
    expect_grant(1, 8'hAA, 1'b0);
    wait_sb(1, "t6_first", 100);
    wait_sb(0, "t6_second", 100);
    check("t6_gap_respected", 32'((last_load_cyc - last_rise_cyc) >= 3), 32'd1);
    wait_idle("t6_idle", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
